muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//  Multi-cycle iterative multiply/divide sequencer that owns the HI/LO register pair.
//  It replaces the single-cycle MULT/MULTU/DIV/DIVU paths with a 32-iteration shift-add
//  multiplier and a restoring divider, which keeps the combinational path short.
//  It sits beside the ALU in the execute stage and requests a pipeline stall when the
//  core needs HI/LO, or wants to start a new op, while an op is still running.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO are WIDTH each; iteration count = WIDTH
// PORTS
//  clk      in   1      rising-edge clock
//  reset    in   1      synchronous, active-high reset
//  start    in   1      launch op; sampled only in IDLE
//  op       in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//  a        in   WIDTH  multiplicand / dividend (rs)
//  b        in   WIDTH  multiplier / divisor (rt)
//  mthi_we  in   1      write wdata to HI (MTHI)
//  mtlo_we  in   1      write wdata to LO (MTLO)
//  wdata    in   WIDTH  data for MTHI/MTLO
//  hilo_rd  in   1      core is reading HI or LO (MFHI/MFLO) this cycle
//  hi       out  WIDTH  HI register (registered)
//  lo       out  WIDTH  LO register (registered)
//  busy     out  1      op in progress (states RUN, FIX)
//  done     out  1      one-cycle pulse when HI/LO hold a new result
//  stall    out  1      combinational: busy & (start | hilo_rd | mthi_we | mtlo_we)
// BEHAVIOUR
//  Reset: state=IDLE, hi=lo=0, busy=0, done=0; reset has priority over all other inputs.
//  States: IDLE -> RUN (start=1) -> FIX -> IDLE.
//  IDLE:
//   - start=1 latches op and the operand magnitudes (|a|, |b| for MULT/DIV; raw for U ops),
//     latches the result sign flags, clears the iteration counter and enters RUN.
//   - mthi_we/mtlo_we write hi/lo on this edge. Both may fire in the same cycle.
//   - An MT write in the same cycle as start does take effect; the op result later overwrites it.
//  RUN:
//   - One iteration per cycle for exactly WIDTH cycles, then FIX.
//   - Multiply: 2*WIDTH-bit product; add the shifted multiplicand when the multiplier LSB is 1.
//   - Divide: restoring; shift the remainder left, trial-subtract the divisor, set the quotient bit.
//  FIX: 1 cycle.
//   - Apply the sign correction.
//   - MULT: negate the 64-bit product if sign(a) != sign(b).
//   - DIV: quotient truncates toward zero; quotient negated if signs differ; remainder
//     takes the sign of the dividend.
//   - On the edge leaving FIX: hi <= upper/remainder, lo <= lower/quotient, done <= 1,
//     state <= IDLE.
//  Latency: start sampled at edge 0; done=1 and hi/lo valid after edge WIDTH+2 (34).
//   busy=1 from edge 1 through edge WIDTH+1. done lasts 1 cycle, and busy=0 while done=1.
//  Back-to-back: start may be sampled in the same cycle done=1 (state is IDLE).
//  While busy:
//   - start is ignored and mthi_we/mtlo_we are ignored; stall holds them until IDLE.
//   - hi/lo outputs keep their old values until the FIX edge.
//  Divide by zero (b=0, DIV or DIVU): no exception; hi=a (unmodified), lo={WIDTH{1'b1}}.
//   Same latency as a normal divide.
//  Overflow DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//  Reset mid-op: aborts immediately; IDLE with hi=lo=0, done=0; no partial result is written.
//  op values are all defined; there is no illegal op.
// TESTING
//  1 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done 34 cycles after start; hi=0xFFFFFFFE lo=0x00000001
//  2 MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; DIV a=0xFFFFFFF9(-7) b=2 ->
//    lo=0xFFFFFFFD hi=0xFFFFFFFF
//  3 DIVU a=100 b=0 -> hi=0x00000064 lo=0xFFFFFFFF;
//    DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0
//  4 start MULTU 3*5; hilo_rd=1 from cycle 5 -> stall=1 until the done cycle, stall=0 when
//    done=1; then lo=15 hi=0
//  5 start DIVU 9/2; pulse reset at cycle 10 -> next cycle busy=0 hi=lo=0, no done pulse
//  6 IDLE: mthi_we=1, mtlo_we=1, wdata=0x12345678 -> hi=lo=0x12345678;
//    while busy mthi_we=1 -> stall=1, hi unchanged

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer owning the HI/LO pair: shift-add multiplier,
// restoring divider, one iteration per cycle, sign fix-up in a final cycle.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             hilo_rd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic             is_div, neg_q, neg_r, div0;
  logic [WIDTH-1:0] opnd;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc;    // product upper half or partial remainder
  logic [WIDTH-1:0] lq;     // multiplier/product lower half or dividend/quotient

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             last_iter;

  assign a_neg     = op[0] & a[WIDTH-1];
  assign b_neg     = op[0] & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
  assign last_iter = (cnt == CW'(WIDTH));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last_iter) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy  = (state == RUN) || (state == FIX);
    stall = busy & (start | hilo_rd | mthi_we | mtlo_we);
  end

  // One iteration of each algorithm.
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] it_acc, it_lq;

  always_comb begin
    mul_sum  = {1'b0, acc} + {1'b0, (lq[0] ? opnd : {WIDTH{1'b0}})};
    div_sh   = {acc, lq[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd};
    div_ge   = (div_sh >= {1'b0, opnd});
    if (is_div) begin
      it_acc = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      it_lq  = {lq[WIDTH-2:0], div_ge};
    end else begin
      it_acc = mul_sum[WIDTH:1];
      it_lq  = {mul_sum[0], lq[WIDTH-1:1]};
    end
  end

  // Sign correction applied on the edge leaving FIX.
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix, fix_hi, fix_lo;

  always_comb begin
    prod     = {acc, lq};
    prod_fix = neg_q ? -prod : prod;
    q_fix    = div0 ? {WIDTH{1'b1}} : (neg_q ? -lq : lq);
    r_fix    = neg_r ? -acc : acc;
    fix_hi   = is_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = is_div ? q_fix : prod_fix[WIDTH-1:0];
  end

  // NOTE: datapath registers are always loaded before use, so they carry no reset.
  // The first RUN cycle only primes the counter; the WIDTH iterations follow on the next edges.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      is_div <= op[1];
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= op[1] & a_neg;
      div0   <= op[1] & (b == '0);
      opnd   <= op[1] ? b_mag : a_mag;
      lq     <= op[1] ? a_mag : b_mag;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      cnt <= cnt + CW'(1);
      if (cnt != '0) begin
        acc <= it_acc;
        lq  <= it_lq;
      end
    end
  end

  // Architectural HI/LO and the done pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == FIX);
      if (state == FIX) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end else if (state == IDLE) begin
        if (mthi_we) hi <= wdata;
        if (mtlo_we) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus random ops against
// an arithmetic reference model.
module tb_muldiv_seq;

  logic        clk, reset, start, mthi_we, mtlo_we, hilo_rd;
  logic [1:0]  op;
  logic [31:0] a, b, wdata, hi, lo;
  logic        busy, done, stall;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_hi, exp_lo;
  int          rd_from = -1;
  bit          mt_busy = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wdata(wdata), .hilo_rd(hilo_rd),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  // Reference: plain 64-bit arithmetic with the architectural special cases.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] h, output logic [31:0] l);
    longint unsigned pu;
    longint          ps, sx, sy;
    case (o)
      2'b00: begin pu = 64'(x) * 64'(y); h = pu[63:32]; l = pu[31:0]; end
      2'b01: begin
        ps = longint'($signed(x)) * longint'($signed(y));
        h = ps[63:32]; l = ps[31:0];
      end
      2'b10: begin
        if (y == 0) begin h = x; l = '1; end
        else begin l = x / y; h = x % y; end
      end
      default: begin
        if (y == 0) begin h = x; l = '1; end
        else begin
          sx = longint'($signed(x)); sy = longint'($signed(y));
          l = 32'(sx / sy); h = 32'(sx % sy);
        end
      end
    endcase
  endfunction

  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit mt_start);
    logic [31:0] eh, el;
    int cyc;
    model(o, x, y, eh, el);
    op = o; a = x; b = y; start = 1'b1;
    if (mt_start) begin mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'h0BAD_F00D; end
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    if (mt_start) begin
      mthi_we = 1'b0; mtlo_we = 1'b0;
      exp_hi = 32'h0BAD_F00D; exp_lo = 32'h0BAD_F00D;
    end
    chk("done_one_cycle", done, 0);
    cyc = 0;
    while (cyc < 40 && !done) begin
      chk("busy_run", busy, 1);
      chk("hi_hold", hi, exp_hi);
      chk("lo_hold", lo, exp_lo);
      hilo_rd = (rd_from >= 0 && cyc >= rd_from);
      mthi_we = mt_busy && cyc >= 3 && cyc <= 10;
      wdata   = 32'hFEED_FACE;
      start   = (cyc == 7);
      op      = 2'($urandom_range(0, 3));
      #1;
      chk("stall_busy", stall, hilo_rd | mthi_we | start);
      @(posedge clk); #1;
      start = 1'b0; mthi_we = 1'b0;
      cyc++;
    end
    chk("latency", cyc, 34);
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 0);
    chk("stall_done", stall, 0);
    chk("hi_result", hi, eh);
    chk("lo_result", lo, el);
    hilo_rd = 1'b0;
    exp_hi = eh; exp_lo = el;
  endtask

  initial begin
    reset = 1'b1; start = 0; op = 0; a = 0; b = 0;
    mthi_we = 0; mtlo_we = 0; wdata = 0; hilo_rd = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    reset = 1'b0;
    exp_hi = 0; exp_lo = 0;

    // MTHI and MTLO together while idle.
    mthi_we = 1; mtlo_we = 1; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    mthi_we = 0; mtlo_we = 0;
    chk("mthi_idle", hi, 32'h1234_5678);
    chk("mtlo_idle", lo, 32'h1234_5678);
    exp_hi = 32'h1234_5678; exp_lo = 32'h1234_5678;

    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("t1_hi", exp_hi, 32'hFFFF_FFFE);
    do_op(2'b01, 32'hFFFF_FFFD, 32'd7, 0);
    do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(2'b10, 32'd100, 32'd0, 0);
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(2'b11, 32'hFFFF_FF00, 32'd0, 0);
    do_op(2'b01, 32'h8000_0000, 32'h8000_0000, 0);
    rd_from = 5;
    do_op(2'b00, 32'd3, 32'd5, 0);
    rd_from = -1;
    mt_busy = 1;
    do_op(2'b10, 32'd1000, 32'd7, 0);
    mt_busy = 0;
    do_op(2'b11, 32'd17, 32'hFFFF_FFFB, 1);

    for (int i = 0; i < 20; i++) begin
      logic [31:0] rx, ry;
      rx = $urandom;
      ry = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      do_op(2'($urandom_range(0, 3)), rx, ry, 0);
    end

    // Reset in the middle of a divide aborts it with no result.
    @(posedge clk); #1;
    mthi_we = 1; mtlo_we = 1; wdata = 32'hA5A5_5A5A;
    @(posedge clk); #1;
    mthi_we = 0; mtlo_we = 0;
    op = 2'b10; a = 32'd9; b = 32'd2; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (9) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_hi", hi, 32'hA5A5_5A5A);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_done", done, 0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", done, 0);
    end
    chk("abort_hi_end", hi, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
